// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the multi-cycle ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, N cycles.
module alu_mul_seq #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           done,
   output logic [2*N-1:0] prod
);

   localparam int CW = $clog2(N);

   logic [2*N-1:0] acc;
   logic [2*N-1:0] mc;
   logic [N-1:0]   mp;
   logic [CW-1:0]  cnt;
   logic           busy;

   // prod is the accumulator including this cycle's partial product,
   // so it is already final while done is high.
   assign prod = acc + (mp[0] ? mc : '0);
   assign done = busy && (cnt == CW'(N-1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc  <= '0;
         mc   <= '0;
         mp   <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         acc  <= '0;
         mc   <= {{N{1'b0}}, a};
         mp   <= b;
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         acc  <= prod;
         mc   <= mc << 1;
         mp   <= mp >> 1;
         cnt  <= cnt + 1'b1;
         busy <= !done;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake; MUL built only when
// ALU_MC_MUL_EN is defined, otherwise MUL reports op_err.
module alu_mc
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   alu_op,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] alu_out,
   output logic [N-1:0] alu_hi,
   output logic         z,
   output logic         c,
   output logic         v,
   output logic         n,
   output logic         op_err
);

   localparam int SW = $clog2(N);

   state_t         state;
   state_t         state_nxt;
   op_t            op;
   logic [SW-1:0]  amt;
   logic [N-1:0]   res;
   logic           cf;
   logic           vf;
   logic           ef;
   logic           is_mul;
   logic           accept;
   logic           mul_done;
   logic [2*N-1:0] mul_prod;

   assign op       = op_t'(alu_op);
   assign is_mul   = (op == OP_MUL);
   assign in_ready = rst_n && (state == S_IDLE);
   assign accept   = (state == S_IDLE) && in_valid;
   assign out_valid = (state == S_DONE);
   assign amt      = SW'(32'(in2) % 32'(N));

`ifdef ALU_MC_MUL_EN
   alu_mul_seq #(.N(N)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept && is_mul),
      .a     (in1),
      .b     (in2),
      .done  (mul_done),
      .prod  (mul_prod)
   );
`else
   assign mul_done = 1'b0;
   assign mul_prod = '0;
`endif

   always_comb begin
      res = '0;
      cf  = 1'b0;
      vf  = 1'b0;
      ef  = 1'b0;
      unique case (op)
         OP_ADD: begin
            {cf, res} = {1'b0, in1} + {1'b0, in2};
            vf = (in1[N-1] == in2[N-1]) && (res[N-1] != in1[N-1]);
         end
         OP_SUB: begin
            {cf, res} = {1'b0, in1} - {1'b0, in2};
            vf = (in1[N-1] != in2[N-1]) && (res[N-1] != in1[N-1]);
         end
`ifdef ALU_MC_MUL_EN
         OP_MUL: ef = 1'b0;
`else
         OP_MUL: ef = 1'b1;
`endif
         OP_AND: res = in1 & in2;
         OP_OR:  res = in1 | in2;
         OP_XOR: res = in1 ^ in2;
         // extra guard bit catches the last bit shifted out
         OP_SHL: {cf, res} = {1'b0, in1} << amt;
         OP_SHR: {res, cf} = {in1, 1'b0} >> amt;
         default: res = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (in_valid) begin
`ifdef ALU_MC_MUL_EN
               state_nxt = is_mul ? S_BUSY : S_DONE;
`else
               state_nxt = S_DONE;
`endif
            end
         end
         S_BUSY: if (mul_done) state_nxt = S_DONE;
         S_DONE: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_out <= '0;
         alu_hi  <= '0;
         z       <= 1'b0;
         c       <= 1'b0;
         v       <= 1'b0;
         n       <= 1'b0;
         op_err  <= 1'b0;
      end else if (state == S_BUSY && mul_done) begin
         alu_out <= mul_prod[N-1:0];
         alu_hi  <= mul_prod[2*N-1:N];
         z       <= (mul_prod[N-1:0] == '0);
         c       <= (mul_prod[2*N-1:N] != '0);
         v       <= (mul_prod[2*N-1:N] != '0);
         n       <= mul_prod[N-1];
         op_err  <= 1'b0;
      end else if (state_nxt == S_DONE && accept) begin
         alu_out <= res;
         alu_hi  <= '0;
         z       <= (res == '0);
         c       <= cf;
         v       <= vf;
         n       <= res[N-1];
         op_err  <= ef;
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_alu_mc;

   localparam int N = 8;
   localparam int M = 1 << N;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   alu_op;
   logic [N-1:0] in1;
   logic [N-1:0] in2;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] alu_out;
   logic [N-1:0] alu_hi;
   logic         z;
   logic         c;
   logic         v;
   logic         n;
   logic         op_err;

   int vectors = 0;
   int errs    = 0;

   alu_mc #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_out   (alu_out),
      .alu_hi    (alu_hi),
      .z         (z),
      .c         (c),
      .v         (v),
      .n         (n),
      .op_err    (op_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic model(input int op, input int a, input int b,
                        output int lo, output int hi, output int cf,
                        output int vf, output int ef, output int lat);
      int sa, sb, s, r, amt;
      sa = (a >= M/2) ? a - M : a;
      sb = (b >= M/2) ? b - M : b;
      lo = 0; hi = 0; cf = 0; vf = 0; ef = 0; lat = 1;
      amt = b % N;
      case (op)
         0: begin
            r = a + b; lo = r % M; cf = int'(r >= M);
            s = sa + sb; vf = int'(s >= M/2 || s < -M/2);
         end
         1: begin
            lo = (a - b + M) % M; cf = int'(a < b);
            s = sa - sb; vf = int'(s >= M/2 || s < -M/2);
         end
         2: begin
`ifdef ALU_MC_MUL_EN
            r = a * b; lo = r % M; hi = r / M;
            cf = int'(hi != 0); vf = cf; lat = N + 1;
`else
            ef = 1;
`endif
         end
         3: lo = a & b;
         4: lo = a | b;
         5: lo = a ^ b;
         6: begin
            r = a << amt; lo = r % M;
            cf = (amt != 0) ? (r / M) % 2 : 0;
         end
         default: begin
            lo = a >> amt;
            cf = (amt != 0) ? (a >> (amt - 1)) % 2 : 0;
         end
      endcase
   endtask

   task automatic run(input string tag, input int op, input int a,
                      input int b, input int hold);
      int lo, hi, cf, vf, ef, lat, got_lat;
      model(op, a, b, lo, hi, cf, vf, ef, lat);
      chk({tag, ":in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      alu_op   = 3'(op);
      in1      = N'(a);
      in2      = N'(b);
      @(negedge clk);
      in_valid = 1'b0;
      alu_op   = 3'($urandom);
      in1      = N'($urandom);
      in2      = N'($urandom);
      got_lat  = 1;
      while (!out_valid && got_lat < 3 * N) begin
         @(negedge clk);
         got_lat++;
      end
      chk({tag, ":lat"}, got_lat, lat);
      chk({tag, ":out"}, alu_out, lo);
      chk({tag, ":hi"}, alu_hi, hi);
      chk({tag, ":z"}, z, int'(lo == 0));
      chk({tag, ":c"}, c, cf);
      chk({tag, ":v"}, v, vf);
      chk({tag, ":n"}, n, int'(lo >= M/2));
      chk({tag, ":err"}, op_err, ef);
      repeat (hold) begin
         in1 = N'($urandom);
         @(negedge clk);
         chk({tag, ":hold_out"}, alu_out, lo);
         chk({tag, ":hold_valid"}, out_valid, 1);
         chk({tag, ":hold_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ":drain_valid"}, out_valid, 0);
      chk({tag, ":drain_ready"}, in_ready, 1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_op    = '0;
      in1       = '0;
      in2       = '0;
      repeat (3) @(negedge clk);
      chk("rst:out_valid", out_valid, 0);
      chk("rst:in_ready", in_ready, 0);
      chk("rst:out", {alu_out, alu_hi, z, c, v, n, op_err}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst:ready_after", in_ready, 1);

      run("add_200_100", 0, 200, 100, 0);
      run("sub_5_5", 1, 5, 5, 0);
      run("sub_3_5", 1, 3, 5, 0);
      run("mul_255_255", 2, 255, 255, 1);
      run("add_127_1", 0, 127, 1, 5);
      run("shl_81_9", 6, 8'h81, 9, 0);
      run("shr_81_0", 7, 8'h81, 0, 0);
      run("shr_81_7", 7, 8'h81, 7, 0);
      run("and", 3, 8'hF0, 8'h3C, 0);
      run("or", 4, 8'hF0, 8'h0C, 0);
      run("xor", 5, 8'hFF, 8'hFF, 0);
      run("sub_80_1", 1, 8'h80, 1, 0);

      // reset during the 4th busy cycle of a multiply
      in_valid = 1'b1;
      alu_op   = 3'd2;
      in1      = 8'd13;
      in2      = 8'd11;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst:out_valid", out_valid, 0);
      chk("midrst:in_ready", in_ready, 0);
      chk("midrst:out", {alu_out, alu_hi, z, c, v, n, op_err}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst:out_valid2", out_valid, 0);
      run("add_1_1", 0, 1, 1, 0);

      for (int i = 0; i < 60; i++)
         run("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, M-1)),
             int'($urandom_range(0, M-1)), int'($urandom_range(0, 3)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
